// File: rtl/sequential_left_shifter.sv
// Multi-cycle signed arithmetic left shifter, one bit per clock, with overflow
// detection and optional saturation under a start/done handshake.
module sequential_left_shifter #(
    parameter int N        = 8,
    parameter int SW       = 3,
    parameter int SATURATE = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [N-1:0]  input_data,
    input  logic [SW-1:0] shamt,
    output logic          busy,
    output logic          done,
    output logic [N-1:0]  shifted_result,
    output logic          overflow
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam logic [SW-1:0] CNT_ONE = SW'(1);
    localparam logic [N-1:0]  MAX_POS = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0]  MIN_NEG = {1'b1, {(N-1){1'b0}}};

    state_t        state;
    logic [N-1:0]  work_reg;
    logic          sign_reg;
    logic          ovf;
    logic [SW-1:0] cnt;

    logic [N-1:0]  work_next;
    logic          ovf_next;

    // The final shift step feeds the result registers directly, so outputs are
    // valid in the very cycle DONE is entered.
    assign work_next = {work_reg[N-2:0], 1'b0};
    assign ovf_next  = ovf | (work_reg[N-1] ^ work_reg[N-2]);

    function automatic logic [N-1:0] finalize(input logic [N-1:0] w,
                                              input logic         s,
                                              input logic         o);
        if (SATURATE != 0 && o)
            return s ? MIN_NEG : MAX_POS;
        return w;
    endfunction

    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values; blocking would chain work_reg into ovf.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            work_reg       <= '0;
            sign_reg       <= 1'b0;
            ovf            <= 1'b0;
            cnt            <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            shifted_result <= '0;
            overflow       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        work_reg <= input_data;
                        sign_reg <= input_data[N-1];
                        ovf      <= 1'b0;
                        cnt      <= shamt;
                        busy     <= 1'b1;
                        if (shamt == '0) begin
                            state          <= DONE;
                            done           <= 1'b1;
                            shifted_result <= input_data;
                            overflow       <= 1'b0;
                        end else begin
                            state <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    work_reg <= work_next;
                    ovf      <= ovf_next;
                    cnt      <= cnt - CNT_ONE;
                    if (cnt == CNT_ONE) begin
                        state          <= DONE;
                        done           <= 1'b1;
                        shifted_result <= finalize(work_next, sign_reg, ovf_next);
                        overflow       <= ovf_next;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
